// File: rtl/configs_loader.sv
// configs_loader: packs a byte stream into 32-bit words and strobes one-hot latch enables with setup/hold margins.
// Optional checksum phase built when CFG_LOADER_CHECKSUM_EN is defined.
module configs_loader #(
    parameter int NUM_WORDS = 43,
    parameter int WORD_W    = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 io_start,
    input  logic                 io_in_valid,
    input  logic [7:0]           io_in_data,
    output logic                 io_in_ready,
    output logic [WORD_W-1:0]    io_d_out,
    output logic [NUM_WORDS-1:0] io_configs_en,
    output logic                 io_busy,
    output logic                 io_done,
    output logic                 io_error
);
    localparam int IW = $clog2(NUM_WORDS);
    localparam logic [IW-1:0] LAST = IW'(NUM_WORDS - 1);

    typedef enum logic [2:0] {IDLE, COLLECT, SETUP, STROBE, HOLD, DONE} state_t;

    state_t state, state_nx;
    logic [IW-1:0] widx;
    logic [1:0] bcnt;
    logic [23:0] asm_r;
    logic [WORD_W-1:0] word;
    logic xfer, last, go, ck;

    assign xfer = io_in_valid & io_in_ready;
    assign word = {io_in_data, asm_r};
    assign last = widx == LAST;
    assign go = io_start & (state == IDLE || state == DONE);
    assign io_in_ready = state == COLLECT;
    assign io_busy = state inside {COLLECT, SETUP, STROBE, HOLD};
    assign io_done = state == DONE;
    assign io_configs_en = (state == STROBE) ? NUM_WORDS'(1) << widx : '0;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state decode; the checksum word skips straight to DONE
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: state_nx = io_start ? COLLECT : state;
            COLLECT:    state_nx = (xfer && bcnt == 2'd3) ? (ck ? DONE : SETUP) : COLLECT;
            SETUP:      state_nx = STROBE;
            STROBE:     state_nx = HOLD;
            HOLD:       state_nx = last && !ck ? `ifdef CFG_LOADER_CHECKSUM_EN COLLECT `else DONE `endif : COLLECT;
            default:    state_nx = IDLE;
        endcase
    end

    // Byte assembly, word bus and word index
    always_ff @(posedge clk) begin
        if (reset) begin
            widx <= '0;
            bcnt <= '0;
            asm_r <= '0;
            io_d_out <= '0;
        end else begin
            if (go) begin
                widx <= '0;
                bcnt <= '0;
            end
            if (xfer) begin
                bcnt <= bcnt + 2'd1;
                asm_r <= {io_in_data, asm_r[23:8]};
                if (bcnt == 2'd3 && !ck) io_d_out <= word;
            end
            if (state == HOLD && !last) widx <= widx + 1'b1;
        end
    end

`ifdef CFG_LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] sum;

    // Running sum of loaded words and the final checksum compare
    always_ff @(posedge clk) begin
        if (reset) begin
            ck <= 1'b0;
            sum <= '0;
            io_error <= 1'b0;
        end else begin
            if (go) begin
                ck <= 1'b0;
                sum <= '0;
                io_error <= 1'b0;
            end
            if (state == HOLD) begin
                sum <= sum + io_d_out;
                if (last) ck <= 1'b1;
            end
            if (xfer && bcnt == 2'd3 && ck) io_error <= word != sum;
        end
    end
`else
    assign ck = 1'b0;
    assign io_error = 1'b0;
`endif
endmodule

// File: tb/tb_configs_loader.sv
// tb_configs_loader: directed self-checking bench for configs_loader.
module tb_configs_loader;
    localparam int NW = 43;
`ifdef CFG_LOADER_CHECKSUM_EN
    localparam int LOAD_CYC = 306;
`else
    localparam int LOAD_CYC = 302;
`endif

    logic clk = 0, reset = 1, io_start = 0, io_in_valid = 0;
    logic [7:0] io_in_data = 0;
    logic io_in_ready, io_busy, io_done, io_error;
    logic [31:0] io_d_out;
    logic [NW-1:0] io_configs_en;
    int errors = 0, checks = 0;
    int cyc, k;

    configs_loader #(.NUM_WORDS(NW), .WORD_W(32)) dut (
        .clk(clk), .reset(reset), .io_start(io_start), .io_in_valid(io_in_valid),
        .io_in_data(io_in_data), .io_in_ready(io_in_ready), .io_d_out(io_d_out),
        .io_configs_en(io_configs_en), .io_busy(io_busy), .io_done(io_done), .io_error(io_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word_of(input int w);
        logic [31:0] r;
        for (int j = 0; j < 4; j++) r[8*j +: 8] = 8'(4*w + j);
        return r;
    endfunction

    // Streams bytes 0,1,2,...; once all words are sent the checksum (sum + off) follows.
    task automatic run_load(input bit tog, input bit pulse, input int stop_w, input int off,
                            output int c, output int n);
        int b = 0;
        bit ph = 1, acc, was_en = 0;
        logic [31:0] cs = 32'(off), held = 0;
        for (int w = 0; w < NW; w++) cs += word_of(w);
        n = 0;
        io_start = 1;
        tick;
        io_start = 0;
        c = 1;
        while (!io_done && c < 3000) begin
            io_in_valid = tog ? ph : 1'b1;
            ph = ~ph;
            io_in_data = (b < 4*NW) ? 8'(b) : cs[8*((b - 4*NW) & 3) +: 8];
            io_start = pulse && (c % 37 == 5);
            acc = io_in_valid & io_in_ready;
            tick;
            c++;
            if (acc) b++;
            if (was_en) chk("d_out_hold", io_d_out, held);
            was_en = io_configs_en != 0;
            if (was_en) begin
                held = io_d_out;
                chk("en_onehot", io_configs_en, {{(NW-1){1'b0}}, 1'b1} << n);
                chk("d_out_word", io_d_out, word_of(n));
                if (n == stop_w) begin
                    io_start = 0;
                    return;
                end
                n++;
            end
        end
        io_start = 0;
        chk("done_seen", io_done, 1'b1);
    endtask

    initial begin
        tick;
        tick;
        reset = 0;
        io_in_valid = 1;
        io_in_data = 8'h5a;
        for (int i = 0; i < 10; i++)
            chk("idle_outputs", {io_in_ready, io_busy, io_done, io_error, io_configs_en, io_d_out}, 0);

        run_load(0, 0, -1, 0, cyc, k);
        chk("cont_cycles", cyc, LOAD_CYC);
        chk("cont_words", k, NW);
        chk("last_word", io_d_out, 32'hABAAA9A8);
        chk("cont_error", io_error, 1'b0);
        tick;
        tick;
        chk("done_held", {io_done, io_busy, io_in_ready}, 3'b100);

        run_load(1, 0, -1, 0, cyc, k);
        chk("tog_words", k, NW);
        chk("tog_done", {io_done, io_busy}, 2'b10);

        run_load(0, 0, 20, 0, cyc, k);
        chk("strobe_20", io_configs_en[20], 1'b1);
        chk("busy_mid", io_busy, 1'b1);
        reset = 1;
        tick;
        reset = 0;
        chk("reset_mid", {io_busy, io_done, io_in_ready, io_configs_en}, 0);
        chk("reset_dout", io_d_out, 0);

        run_load(0, 1, -1, 0, cyc, k);
        chk("pulse_cycles", cyc, LOAD_CYC);
        chk("pulse_words", k, NW);

`ifdef CFG_LOADER_CHECKSUM_EN
        run_load(0, 0, -1, 1, cyc, k);
        chk("bad_sum_words", k, NW);
        chk("bad_sum_flags", {io_done, io_error}, 2'b11);
        io_start = 1;
        tick;
        io_start = 0;
        chk("start_clears", {io_done, io_error, io_busy}, 3'b001);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/configs_loader.md
# configs_loader

Sequencer on the write side of the tile's configuration latch bank. Accepts a byte-wide configuration stream over a valid/ready handshake, packs bytes into 32-bit words, and drives the shared word bus plus a one-hot per-word latch enable with setup and hold margins around each enable pulse. Sits between the chip-level configuration port and the configuration latches of one LUT tile; one instance per tile.

## Interface
- NUM_WORDS, 43, number of 32-bit configuration words (latch enables) in the tile
- WORD_W, 32, word width; fixed at 32 (4 bytes per word)
- clk  input  1  single clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- io_start  input  1  one-cycle pulse; begins a load from word 0
- io_in_valid  input  1  byte on io_in_data is valid
- io_in_data  input  8  stream byte; little-endian within a word (first byte -> bits [7:0])
- io_in_ready  output  1  loader accepts a byte this cycle (transfer = valid & ready)
- io_d_out  output  32  word bus to latch data input
- io_configs_en  output  NUM_WORDS  one-hot latch enable; bit k loads word k
- io_busy  output  1  load in progress
- io_done  output  1  load complete; held until next io_start
- io_error  output  1  checksum mismatch (see Configuration); held until next io_start

## Operation
- States: IDLE, COLLECT, SETUP, STROBE, HOLD, DONE.
- Reset: state IDLE; io_d_out = 0, io_configs_en = 0, io_in_ready = 0, io_busy = 0, io_done = 0, io_error = 0; word index and byte count = 0; sum register = 0.
- IDLE/DONE: io_start -> COLLECT, word index 0, byte count 0, io_done and io_error cleared, sum cleared.
- COLLECT: io_in_ready = 1; each transfer shifts byte into assembly register at byte position byte_count; after 4th byte -> SETUP with assembled word copied to io_d_out.
- SETUP: 1 cycle, io_d_out stable, enables 0, io_in_ready = 0.
- STROBE: 1 cycle, io_configs_en[word_index] = 1 only, io_d_out unchanged.
- HOLD: 1 cycle, enables 0, io_d_out unchanged; sum += word (mod 2^32). If word_index == NUM_WORDS-1 -> DONE (or checksum phase, see Configuration); else word_index+1, -> COLLECT.
- io_d_out changes only on the COLLECT->SETUP edge; retains last word otherwise.
- io_start while busy: ignored. io_in_valid outside COLLECT: not accepted (ready low), byte remains on bus for upstream.
- Reset mid-load: next edge returns to IDLE, enables drop to 0, partial word discarded; latches already loaded are not touched.
- io_busy = 1 in COLLECT/SETUP/STROBE/HOLD (and checksum phase).

## Timing
- io_in_ready is a registered function of state; no combinational path from io_in_valid to io_in_ready.
- Per word: 4 byte transfers + 3 cycles (SETUP, STROBE, HOLD). Minimum full load with valid held high: 1 + NUM_WORDS*7 cycles from io_start to io_done (302 for 43 words, without checksum).
- Enable pulse exactly 1 cycle; data stable ≥1 cycle before rise and ≥1 cycle after fall.
- io_done rises the cycle after last HOLD (after checksum compare when enabled).

## Configuration
- CFG_LOADER_CHECKSUM_EN defined: after word NUM_WORDS-1 HOLD, return to COLLECT for 4 extra bytes forming a checksum word; no SETUP/STROBE/HOLD and no enable for it; compare with 32-bit sum of all words; mismatch sets io_error in the same cycle io_done rises. Adds 4 transfer cycles.
- Not defined: no checksum phase; io_error tied 0; sum register not built.

## Test plan
- Reset then idle 10 cycles -> all outputs 0, io_in_ready 0, no enable activity.
- io_start, stream bytes 0x00..0xAB continuously -> word 0 = 0x03020100 on io_d_out, io_configs_en = 1<<0 for one cycle, word 42 = 0xABAAA9A8 with en[42]; io_done at cycle 302.
- Stream with io_in_valid toggling 1/0 every cycle -> same words/enables, only transfers counted, one-hot enables never overlap, io_d_out stable SETUP through HOLD.
- Assert reset during word 20 STROBE -> en[20] drops next edge, state IDLE, io_busy 0; new io_start reloads from word 0.
- io_start pulses during load -> ignored, word index unaffected.
- CFG_LOADER_CHECKSUM_EN: append correct sum -> io_done=1, io_error=0; append sum+1 -> io_done=1, io_error=1; no enable for checksum word.
